// File: rtl/shift_sequencer.sv
// Iterative barrel-shifter replacement: performs LSL/LSR/ASR/ROR/RRX one bit per cycle
// behind a valid/ready request and result handshake.
module shift_sequencer #(
  parameter int bus = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [bus-1:0] operand,
  input  logic [7:0]     amount,
  input  logic [1:0]     shift_type,
  input  logic           imm_form,
  input  logic           carry_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [bus-1:0] result,
  output logic           carry_out
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {T_LSL = 2'b00, T_LSR = 2'b01, T_ASR = 2'b10, T_ROR = 2'b11} shift_t;

  state_t         r_state, w_next;
  shift_t         r_type;
  logic           r_rrx;
  logic [5:0]     r_count;
  logic [bus-1:0] r_result;
  logic           r_carry;

  logic [5:0]     w_n;
  logic           w_rrx;
  logic           w_ror_keep;
  logic           w_accept;
  logic [bus-1:0] w_step_result;
  logic           w_step_carry;
  logic [4:0]     w_amt5;

  assign w_amt5   = amount[4:0];
  assign in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

  // Iteration count decode for both amount encodings.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_n        = {1'b0, w_amt5};
    w_rrx      = 1'b0;
    w_ror_keep = 1'b0;
    if (imm_form) begin
      case (shift_t'(shift_type))
        T_LSL:        w_n = {1'b0, w_amt5};
        T_LSR, T_ASR: w_n = (w_amt5 == 5'd0) ? 6'd32 : {1'b0, w_amt5};
        T_ROR: begin
          w_rrx = (w_amt5 == 5'd0);
          w_n   = w_rrx ? 6'd1 : {1'b0, w_amt5};
        end
        default:      w_n = {1'b0, w_amt5};
      endcase
    end else begin
      case (shift_t'(shift_type))
        T_LSL, T_LSR: w_n = (amount > 8'd33) ? 6'd33 : amount[5:0];
        T_ASR:        w_n = (amount > 8'd32) ? 6'd32 : amount[5:0];
        T_ROR: begin
          w_n        = {1'b0, w_amt5};
          w_ror_keep = (amount != 8'd0) && (w_amt5 == 5'd0);
        end
        default:      w_n = {1'b0, w_amt5};
      endcase
    end
  end

  // One single-bit step of the latched operation.
  always_comb begin
    w_step_result = r_result;
    w_step_carry  = r_carry;
    if (r_rrx) begin
      w_step_result = {r_carry, r_result[bus-1:1]};
      w_step_carry  = r_result[0];
    end else begin
      case (r_type)
        T_LSL: begin
          w_step_result = {r_result[bus-2:0], 1'b0};
          w_step_carry  = r_result[bus-1];
        end
        T_LSR: begin
          w_step_result = {1'b0, r_result[bus-1:1]};
          w_step_carry  = r_result[0];
        end
        T_ASR: begin
          w_step_result = {r_result[bus-1], r_result[bus-1:1]};
          w_step_carry  = r_result[0];
        end
        T_ROR: begin
          w_step_result = {r_result[0], r_result[bus-1:1]};
          w_step_carry  = r_result[0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_n != 6'd0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (r_count == 6'd1) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type   <= T_LSL;
      r_rrx    <= 1'b0;
      r_count  <= 6'd0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_type   <= shift_t'(shift_type);
          r_rrx    <= w_rrx;
          r_count  <= w_n;
          r_result <= operand;
          r_carry  <= w_ror_keep ? operand[bus-1] : carry_in;
        end
        S_SHIFT: begin
          r_result <= w_step_result;
          r_carry  <= w_step_carry;
          r_count  <= r_count - 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign carry_out = r_carry;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001: Parameter bus, default 32, sets the operand and result width.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst  input  1  reset, asynchronous and active-high.
REQ-004: in_valid  input  1  request strobe; the fields below are valid while it is high.
REQ-005: in_ready  output  1  high only in IDLE; a request is accepted on in_valid & in_ready.
REQ-006: operand  input  bus  value to shift.
REQ-007: amount  input  8  shift amount; immediate form uses amount[4:0], register form uses amount[7:0].
REQ-008: shift_type  input  2  encoding 00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX.
REQ-009: imm_form  input  1  1 = immediate-encoded amount, 0 = register-specified amount.
REQ-010: carry_in  input  1  current C flag.
REQ-011: out_valid  output  1  result and carry_out are valid.
REQ-012: out_ready  input  1  consumer accepts the result on out_valid & out_ready.
REQ-013: result  output  bus  shifted value.
REQ-014: carry_out  output  1  shifter carry-out.

Function
REQ-015: FSM states are IDLE, SHIFT and DONE; reset enters IDLE.
REQ-016: On accept, operand, shift_type and carry_in are latched into working registers, and the iteration count N is computed as below.
REQ-017: Immediate form sets N = amount[4:0], except amount[4:0]=0 gives LSL N=0, LSR N=32, ASR N=32, and ROR means RRX with N=1.
REQ-018: Register form sets LSL/LSR N = min(amount,33), ASR N = min(amount,32), and ROR N = amount[4:0].
REQ-019: For register-form ROR with amount != 0 and amount[4:0] = 0, N=0, result = operand and carry_out = operand[bus-1].
REQ-020: When N=0 (all cases other than REQ-019), result = operand and carry_out = carry_in.
REQ-021: Each SHIFT cycle performs exactly one single-bit step, and carry_out takes the bit shifted out.
REQ-022: LSL steps shift left with 0 in; LSR steps shift right with 0 in; ASR steps shift right with the sign bit in; ROR steps move bit 0 into the MSB.
REQ-023: An RRX step sets the result to {carry, operand[bus-1:1]} and the carry to operand[0].
REQ-024: IDLE goes to SHIFT on accept when N>0, otherwise directly to DONE.
REQ-025: SHIFT decrements the counter each cycle and goes to DONE after the Nth step.
REQ-026: DONE asserts out_valid and returns to IDLE on out_ready.
REQ-027: Latency is N+1 cycles from the accept edge to out_valid high.
REQ-028: in_ready is low throughout SHIFT and DONE, so at most one request is in flight; the earliest next accept is the cycle after the handshake.
REQ-029: In DONE, result and carry_out hold stable while out_ready is low.
REQ-030: Input changes after accept have no effect on the operation in flight.
REQ-031: The 33-step LSL/LSR produces result 0 and carry 0; the 32-step ASR produces all sign bits with carry = sign.
REQ-032: The counter is 6 bits wide and never wraps.

Reset
REQ-033: rst high forces IDLE asynchronously, including during SHIFT or DONE, and aborts any operation in flight without producing an output.
REQ-034: Reset values are in_ready=1 (while rst is low), out_valid=0, result=0, carry_out=0, and counter=0.

Verification
REQ-035: Immediate LSL #4, operand=0x8000_0001, carry_in=0: out_valid on cycle 5, result=0x0000_0010, carry_out=0.
REQ-036: Immediate LSR #0 (meaning 32), operand=0x8000_0000: result=0, carry_out=1, latency 33.
REQ-037: Immediate ROR #0 (RRX), operand=0x0000_0003, carry_in=1: result=0x8000_0001, carry_out=1, latency 2.
REQ-038: Register ASR with amount=200, operand=0x8000_0000: result=0xFFFF_FFFF, carry_out=1, latency 33.
REQ-039: Register ROR with amount=32, operand=0x8000_0000: N=0, result=0x8000_0000, carry_out=1, latency 1; then register LSL with amount=0, carry_in=1: result=operand, carry_out=1.
REQ-040: Handshake and reset checks: hold out_ready low for 5 cycles in DONE and confirm result is stable and in_ready stays 0; assert rst mid-SHIFT and confirm out_valid=0, in_ready=1 after release, and a fresh request completes correctly.
